// File: rtl/axi_alu_core.sv
// axi_alu_core: two-operand ALU sitting between an 8-bit operand stream and a
// 9-bit result stream. Each transaction collects A, then B, which is sampled
// together with op. The block then presents {flag, value} until the sink takes it.
// Optional feature: define AXI_ALU_SAT_EN for saturating ADD/SUB.
module axi_alu_core #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [1:0]        op,
  output logic [DATA_W:0]   m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  txn_cnt
);

  typedef enum logic [1:0] {
    GET_A = 2'd0,
    GET_B = 2'd1,
    SEND  = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_live;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W:0]     r_res;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_s_fire;
  logic                w_m_fire;
  logic [DATA_W:0]     w_sum;
  logic [DATA_W:0]     w_dif;
  logic [DATA_W:0]     w_res;

  // r_live keeps s_ready low in the reset cycle itself; it rises with the first
  // clock edge after reset is released.
  assign s_ready  = r_live && ((r_state == GET_A) || (r_state == GET_B));
  assign m_valid  = (r_state == SEND);
  assign m_data   = r_res;
  assign txn_cnt  = r_cnt;
  assign w_s_fire = s_valid && s_ready;
  assign w_m_fire = m_valid && m_ready;

  assign w_sum = {1'b0, r_a} + {1'b0, s_data};
  assign w_dif = {1'b0, r_a} - {1'b0, s_data};

  // Result of the current B beat combined with the held A operand.
  always_comb begin
    w_res = '0;
    case (op)
`ifdef AXI_ALU_SAT_EN
      2'b00:   w_res = w_sum[DATA_W] ? {1'b1, {DATA_W{1'b1}}} : w_sum;
      2'b01:   w_res = w_dif[DATA_W] ? {1'b1, {DATA_W{1'b0}}} : w_dif;
`else
      2'b00:   w_res = w_sum;
      2'b01:   w_res = w_dif;
`endif
      2'b10:   w_res = {1'b0, r_a & s_data};
      default: w_res = {1'b0, r_a ^ s_data};
    endcase
  end

  // Transaction FSM: collect A, collect B and compute, present the result.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= GET_A;
      r_live  <= 1'b0;
      r_a     <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        GET_A: begin
          if (w_s_fire) begin
            r_a     <= s_data;
            r_state <= GET_B;
          end
        end
        GET_B: begin
          if (w_s_fire) begin
            r_res   <= w_res;
            r_state <= SEND;
          end
        end
        SEND: begin
          if (w_m_fire) begin
            r_cnt   <= r_cnt + 1'b1;
            r_state <= GET_A;
          end
        end
        default: r_state <= GET_A;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_alu_core.sv
// Testbench for axi_alu_core: directed table, reset/hold corner sequences and
// randomized transactions against an arithmetic reference model.
module tb_axi_alu_core;

`ifdef AXI_ALU_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [1:0] op;
  logic [8:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] txn_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;

  axi_alu_core #(.DATA_W(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .op(op),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .txn_cnt(txn_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] o;
    logic [8:0] exp;
  } vec_t;

  // Reference: plain integer arithmetic following the opcode rules.
  function automatic logic [8:0] model(input int a, input int b, input int o);
    int r;
    case (o)
      0: begin
        r = a + b;
        if (SAT && r > 255) return 9'h1FF;
        return r[8:0];
      end
      1: begin
        if (a < b) return SAT ? 9'h100 : {1'b1, 8'((a - b) & 255)};
        return {1'b0, 8'(a - b)};
      end
      2: return {1'b0, 8'(a & b)};
      default: return {1'b0, 8'(a ^ b)};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic put(input logic [7:0] d, input logic [1:0] o, input int gap);
    int n;
    for (int i = 0; i < gap; i++) @(negedge clk);
    s_data  = d;
    op      = o;
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("s_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    s_valid = 1'b0;
    s_data  = 8'($urandom);
    op      = 2'($urandom);
  endtask

  // Waits for a result, stalls `delay` cycles checking stability, then accepts.
  task automatic get(input int delay, output logic [8:0] d);
    int n;
    n = 0;
    while (!m_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("m_valid_timeout", 32'd0, 32'd1);
    d = m_data;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check("hold_data", 32'(m_data), 32'(d));
      check("hold_valid", 32'(m_valid), 32'd1);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    exp_cnt = (exp_cnt + 1) % 256;
  endtask

  vec_t       vecs[8];
  logic [8:0] got;
  int         a, b, o, n_and;

  initial begin
    vecs[0] = '{8'h05, 8'h03, 2'd0, 9'h008};
    vecs[1] = '{8'hF0, 8'h20, 2'd0, SAT ? 9'h1FF : 9'h110};
    vecs[2] = '{8'h03, 8'h05, 2'd1, SAT ? 9'h100 : 9'h1FE};
    vecs[3] = '{8'hCC, 8'hAA, 2'd2, 9'h088};
    vecs[4] = '{8'hCC, 8'hAA, 2'd3, 9'h066};
    vecs[5] = '{8'hFF, 8'h01, 2'd0, SAT ? 9'h1FF : 9'h100};
    vecs[6] = '{8'h80, 8'h80, 2'd1, 9'h000};
    vecs[7] = '{8'h00, 8'hFF, 2'd1, SAT ? 9'h100 : 9'h101};

    reset = 1'b0; s_data = '0; s_valid = 1'b0; op = '0; m_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_txn_cnt", 32'(txn_cnt), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_s_ready", 32'(s_ready), 32'd1);

    // Directed table: latency, value, counter.
    foreach (vecs[i]) begin
      put(vecs[i].a, 2'($urandom), 0);
      put(vecs[i].b, vecs[i].o, 0);
      check("tbl_latency_valid", 32'(m_valid), 32'd1);
      check("tbl_data", 32'(m_data), 32'(vecs[i].exp));
      check("tbl_s_ready_send", 32'(s_ready), 32'd0);
      get(0, got);
      check("tbl_txn_cnt", 32'(txn_cnt), 32'(exp_cnt));
      check("tbl_s_ready_after", 32'(s_ready), 32'd1);
    end

    // Reset for two cycles while waiting for B; the held A must be discarded.
    put(8'h77, 2'd0, 0);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("midrst_s_ready", 32'(s_ready), 32'd0);
      check("midrst_m_valid", 32'(m_valid), 32'd0);
      check("midrst_txn_cnt", 32'(txn_cnt), 32'd0);
    end
    reset = 1'b1;
    exp_cnt = 0;
    @(negedge clk);
    check("midrst_release_m_valid", 32'(m_valid), 32'd0);
    put(8'h05, 2'd3, 0);
    put(8'h03, 2'd0, 0);
    check("midrst_next_is_a", 32'(m_data), 32'h008);
    get(0, got);
    check("midrst_txn_cnt_after", 32'(txn_cnt), 32'd1);

    // Sink stalls five cycles; the sixth cycle completes the handshake.
    put(8'hCC, 2'd1, 0);
    put(8'hAA, 2'd3, 0);
    for (int i = 0; i < 5; i++) begin
      check("stall_data", 32'(m_data), 32'h066);
      check("stall_valid", 32'(m_valid), 32'd1);
      check("stall_s_ready", 32'(s_ready), 32'd0);
      op = 2'($urandom);
      @(negedge clk);
    end
    check("stall_data6", 32'(m_data), 32'h066);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    exp_cnt = (exp_cnt + 1) % 256;
    check("stall_txn_cnt", 32'(txn_cnt), 32'(exp_cnt));
    check("stall_s_ready_after", 32'(s_ready), 32'd1);

    // Early m_ready while idle changes nothing.
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) @(negedge clk);
    m_ready = 1'b0;
    check("early_ready_cnt", 32'(txn_cnt), 32'(exp_cnt));
    check("early_ready_valid", 32'(m_valid), 32'd0);

    // Random opcodes and operands with random gaps.
    for (int t = 0; t < 40; t++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      o = int'($urandom_range(0, 3));
      put(8'(a), 2'($urandom), int'($urandom_range(0, 2)));
      put(8'(b), 2'(o), int'($urandom_range(0, 2)));
      get(int'($urandom_range(0, 2)), got);
      check("rand_result", 32'(got), 32'(model(a, b, o)));
      check("rand_txn_cnt", 32'(txn_cnt), 32'(exp_cnt));
    end

    // At least 256 AND transactions, ending on a counter wrap to zero.
    n_and = 256 + ((256 - exp_cnt) % 256);
    for (int t = 0; t < n_and; t++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      put(8'(a), 2'($urandom), int'($urandom_range(0, 2)));
      put(8'(b), 2'd2, int'($urandom_range(0, 2)));
      get(int'($urandom_range(0, 2)), got);
      check("and_result", 32'(got), 32'(model(a, b, 2)));
    end
    check("wrap_txn_cnt", 32'(txn_cnt), 32'd0);
    check("wrap_model_cnt", 32'(txn_cnt), 32'(exp_cnt));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
